// File: rtl/dispatch_unit_pkg.sv
// Shared backend types for the dispatch->scheduler interface: sizing, the decoded
// packet, and global producer tags (fu * RS_ENTRIES + entry).
package dispatch_unit_pkg;
  localparam int RS_ENTRIES = 16;
  localparam int NUM_FUS    = 4;
  localparam int ARCH_REGS  = 32;
  localparam int NUM_TAGS   = RS_ENTRIES * NUM_FUS;
  localparam int TAG_W      = $clog2(NUM_TAGS);
  localparam int IDX_W      = $clog2(RS_ENTRIES);
  localparam int REG_W      = $clog2(ARCH_REGS);
  localparam int FU_IDX_W   = $clog2(NUM_FUS);
  // One spare bit so an out-of-range FU select is representable and detectable.
  localparam int FU_W       = FU_IDX_W + 1;

  typedef logic [TAG_W-1:0]    tag_t;
  typedef logic [REG_W-1:0]    reg_t;
  typedef logic [NUM_TAGS-1:0] tag_mask_t;

  typedef struct packed {
    reg_t            rd;
    reg_t            rs1;
    reg_t            rs2;
    logic            use_rs1;
    logic            use_rs2;
    logic            writes_rd;
    logic [FU_W-1:0] fu_sel;
  } disp_packet_t;

  function automatic tag_t make_tag(input logic [FU_IDX_W-1:0] fu,
                                    input logic [IDX_W-1:0]    idx);
    return tag_t'(fu) * tag_t'(RS_ENTRIES) + tag_t'(idx);
  endfunction
endpackage

// File: rtl/dispatch_unit_producer_table.sv
// Per-register producer tracking: two bypassed read ports returning one-hot tag
// masks, one write port, completion clear and flush.
module producer_table
  import dispatch_unit_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      flush,
  input  reg_t      rs1,
  input  reg_t      rs2,
  input  logic      use_rs1,
  input  logic      use_rs2,
  input  tag_mask_t ready_mask,
  input  logic      wr_en,
  input  reg_t      wr_reg,
  input  tag_t      wr_tag,
  output tag_mask_t src_mask
);
  logic [ARCH_REGS-1:0] valid_q, valid_d;
  tag_t                 tag_q [ARCH_REGS];
  logic                 wr_ok;

  assign wr_ok = wr_en && (wr_reg != '0);

  // Reads see the pre-update table, so an instruction never depends on itself.
  always_comb begin
    src_mask = '0;
    if (use_rs1 && rs1 != '0 && valid_q[rs1] && !ready_mask[tag_q[rs1]])
      src_mask[tag_q[rs1]] = 1'b1;
    if (use_rs2 && rs2 != '0 && valid_q[rs2] && !ready_mask[tag_q[rs2]])
      src_mask[tag_q[rs2]] = 1'b1;
  end

  // Write is applied after the completion clear so it wins on the same register.
  always_comb begin
    valid_d = valid_q;
    for (int unsigned i = 0; i < ARCH_REGS; i++) begin
      if (valid_q[i] && ready_mask[tag_q[i]]) valid_d[i] = 1'b0;
    end
    if (wr_ok) valid_d[wr_reg] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < ARCH_REGS; i++) tag_q[i] <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
      if (wr_ok) tag_q[wr_reg] <= wr_tag;
    end
  end
endmodule

// File: rtl/dispatch_unit.sv
// Dispatch stage: 1-entry hold register, FU steering, scheduler handshake and
// dependency mask generation from the producer table.
module dispatch_unit
  import dispatch_unit_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  disp_packet_t              in_pkt,
  input  logic [NUM_FUS-1:0]        rs_full,
  input  logic [NUM_FUS*IDX_W-1:0]  rs_entry_idx,
  output logic [NUM_FUS-1:0]        disp_valid,
  output disp_packet_t              disp_pkt,
  output logic [NUM_TAGS-1:0]       dependency_mask,
  input  logic [NUM_TAGS-1:0]       global_ready_mask
);
  disp_packet_t        hold_q, hold_d;
  logic                hold_valid_q, hold_valid_d;
  logic [FU_IDX_W-1:0] fu_idx;
  logic [IDX_W-1:0]    entry_idx;
  logic                fu_ok, fire, accept;
  tag_t                new_tag;
  tag_mask_t           src_mask;

  always_comb begin
    fu_idx    = hold_q.fu_sel[FU_IDX_W-1:0];
    fu_ok     = hold_q.fu_sel < FU_W'(NUM_FUS);
    entry_idx = rs_entry_idx[fu_idx*IDX_W +: IDX_W];
    new_tag   = make_tag(fu_idx, entry_idx);
    fire      = rst && !flush && hold_valid_q && fu_ok && !rs_full[fu_idx];
    in_ready  = rst && !flush && (!hold_valid_q || fire);
    accept    = in_valid && in_ready;
  end

  always_comb begin
    disp_valid      = fire ? (NUM_FUS'(1) << fu_idx) : '0;
    disp_pkt        = hold_q;
    dependency_mask = hold_valid_q ? src_mask : '0;
  end

  always_comb begin
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    if (flush) begin
      hold_valid_d = 1'b0;
    end else if (accept) begin
      hold_d       = in_pkt;
      hold_valid_d = 1'b1;
    end else if (fire) begin
      hold_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
    end
  end

  producer_table u_table (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .rs1        (hold_q.rs1),
    .rs2        (hold_q.rs2),
    .use_rs1    (hold_q.use_rs1),
    .use_rs2    (hold_q.use_rs2),
    .ready_mask (global_ready_mask),
    .wr_en      (fire && hold_q.writes_rd),
    .wr_reg     (hold_q.rd),
    .wr_tag     (new_tag),
    .src_mask   (src_mask)
  );

  // An out-of-range FU select would stall the stage forever.
  a_fu_in_range: assert property (@(posedge clk) disable iff (!rst)
                                  !(hold_valid_q && !fu_ok));
endmodule

// File: tb/tb_dispatch_unit.sv
// Directed bench for dispatch_unit: behavioural producer/hold model checked every
// cycle, plus hand-computed literal expectations along the scenario.
module tb_dispatch_unit;
  import dispatch_unit_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst, flush, in_valid, in_ready;
  disp_packet_t             in_pkt, disp_pkt;
  logic [NUM_FUS-1:0]       rs_full, disp_valid;
  logic [NUM_FUS*IDX_W-1:0] rs_entry_idx;
  logic [NUM_TAGS-1:0]      dependency_mask, grm;

  int checks = 0;
  int passes = 0;
  bit cmp_en = 1'b0;

  dispatch_unit dut (
    .clk               (clk),
    .rst               (rst),
    .flush             (flush),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_pkt            (in_pkt),
    .rs_full           (rs_full),
    .rs_entry_idx      (rs_entry_idx),
    .disp_valid        (disp_valid),
    .disp_pkt          (disp_pkt),
    .dependency_mask   (dependency_mask),
    .global_ready_mask (grm)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic disp_packet_t mk(input int rd, input int rs1, input int rs2,
                                      input bit u1, input bit u2, input bit w, input int fu);
    disp_packet_t p;
    p.rd = REG_W'(rd);  p.rs1 = REG_W'(rs1);  p.rs2 = REG_W'(rs2);
    p.use_rs1 = u1;     p.use_rs2 = u2;       p.writes_rd = w;
    p.fu_sel = FU_W'(fu);
    return p;
  endfunction

  task automatic set_idx(input int f, input int v);
    rs_entry_idx[f*IDX_W +: IDX_W] = IDX_W'(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: register -> (producing, tag) and a one-slot hold.
  bit           m_hv;
  disp_packet_t m_hold;
  bit           m_tv [ARCH_REGS];
  int           m_tt [ARCH_REGS];

  function automatic logic [63:0] src_bit(input bit use_r, input logic [REG_W-1:0] r);
    logic [63:0] m;
    m = '0;
    if (use_r && r != 0 && m_tv[r] && !grm[m_tt[r]]) m[m_tt[r]] = 1'b1;
    return m;
  endfunction

  initial begin : compare
    int          fu;
    bit          fires, rdy;
    logic [63:0] em;
    logic [3:0]  edv;
    wait (cmp_en);
    m_hv = 1'b0;
    m_hold = '0;
    for (int r = 0; r < ARCH_REGS; r++) begin
      m_tv[r] = 1'b0;
      m_tt[r] = 0;
    end
    forever begin
      @(negedge clk);
      fu    = int'(m_hold.fu_sel);
      fires = rst && !flush && m_hv && (fu < NUM_FUS) && rs_full[fu[1:0]] == 1'b0;
      rdy   = rst && !flush && (!m_hv || fires);
      edv   = fires ? 4'(1 << fu) : 4'd0;
      em    = '0;
      if (m_hv) em = src_bit(m_hold.use_rs1, m_hold.rs1) | src_bit(m_hold.use_rs2, m_hold.rs2);
      check("model in_ready", 64'(in_ready), 64'(rdy));
      check("model disp_valid", 64'(disp_valid), 64'(edv));
      check("model dependency_mask", 64'(dependency_mask), em);
      check("model disp_pkt", 64'(disp_pkt), 64'(m_hold));
      if (!rst) begin
        m_hv = 1'b0;
        m_hold = '0;
        for (int r = 0; r < ARCH_REGS; r++) m_tv[r] = 1'b0;
      end else if (flush) begin
        m_hv = 1'b0;
        for (int r = 0; r < ARCH_REGS; r++) m_tv[r] = 1'b0;
      end else begin
        for (int r = 0; r < ARCH_REGS; r++)
          if (m_tv[r] && grm[m_tt[r]]) m_tv[r] = 1'b0;
        if (fires && m_hold.writes_rd && m_hold.rd != 0) begin
          m_tv[m_hold.rd] = 1'b1;
          m_tt[m_hold.rd] = fu * RS_ENTRIES + int'(rs_entry_idx[fu*IDX_W +: IDX_W]);
        end
        if (in_valid && rdy) begin
          m_hold = in_pkt;
          m_hv   = 1'b1;
        end else if (fires) begin
          m_hv = 1'b0;
        end
      end
    end
  end

  initial begin : stim
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pkt = '0;
    rs_full = '0; rs_entry_idx = '0; grm = '0;
    tick(); tick();
    cmp_en = 1'b1;
    #3;
    check("reset in_ready", 64'(in_ready), 64'd0);
    check("reset disp_valid", 64'(disp_valid), 64'd0);
    check("reset mask", 64'(dependency_mask), 64'd0);
    check("reset disp_pkt", 64'(disp_pkt), 64'd0);

    // rd=5 to fu1 entry 3 -> tag 19
    tick();
    rst = 1'b1; in_valid = 1'b1; in_pkt = mk(5, 0, 0, 0, 0, 1, 1); set_idx(1, 3);
    #3 check("t1 in_ready", 64'(in_ready), 64'd1);
    tick();
    in_pkt = mk(0, 5, 0, 1, 0, 0, 0); set_idx(0, 2);
    #3 check("t1 disp_valid", 64'(disp_valid), 64'b0010);
    check("t1 mask", 64'(dependency_mask), 64'd0);
    tick();
    in_valid = 1'b0; rs_full = 4'b0001;
    #3 check("t2 mask bit19", 64'(dependency_mask), 64'h0000_0000_0008_0000);
    check("t2 stall disp_valid", 64'(disp_valid), 64'd0);
    tick();
    rs_full = '0; grm = 64'h0000_0000_0008_0000;
    #3 check("t2 bypass mask", 64'(dependency_mask), 64'd0);
    check("t2 disp_valid", 64'(disp_valid), 64'b0001);
    tick();
    grm = '0;

    // rd=7 -> tag 4; then fu2 stall for 3 cycles
    in_valid = 1'b1; in_pkt = mk(7, 0, 0, 0, 0, 1, 0); set_idx(0, 4);
    tick();
    in_pkt = mk(10, 0, 0, 0, 0, 1, 2); set_idx(2, 5);
    #3 check("t3 pre disp_valid", 64'(disp_valid), 64'b0001);
    tick();
    rs_full = 4'b0100; in_pkt = mk(7, 7, 0, 1, 0, 1, 0); set_idx(0, 9);
    for (int i = 0; i < 3; i++) begin
      #3;
      check("t3 stall disp_valid", 64'(disp_valid), 64'd0);
      check("t3 stall in_ready", 64'(in_ready), 64'd0);
      check("t3 stall pkt", 64'(disp_pkt), 64'(mk(10, 0, 0, 0, 0, 1, 2)));
      tick();
    end
    rs_full = '0;
    #3 check("t3 fire disp_valid", 64'(disp_valid), 64'b0100);
    check("t3 fire in_ready", 64'(in_ready), 64'd1);
    tick();
    // rd=rs1=7 reads old tag 4, writes tag 9
    in_pkt = mk(0, 0, 7, 0, 1, 0, 1);
    #3 check("t4 mask bit4", 64'(dependency_mask), 64'h10);
    check("t4 disp_valid", 64'(disp_valid), 64'b0001);
    tick();
    in_pkt = mk(3, 0, 0, 0, 0, 1, 1); set_idx(1, 6);
    #3 check("t4 table7 tag9", 64'(dependency_mask), 64'h200);
    tick();
    // rd=3 tag 22, then rd=3 tag 23 while 22 completes
    in_pkt = mk(3, 0, 0, 0, 0, 1, 1);
    #3 check("t5 E disp_valid", 64'(disp_valid), 64'b0010);
    tick();
    set_idx(1, 7); grm = 64'h0000_0000_0040_0000; in_pkt = mk(0, 3, 0, 1, 0, 0, 0);
    #3 check("t5 F disp_valid", 64'(disp_valid), 64'b0010);
    tick();
    grm = '0; in_pkt = mk(0, 0, 0, 1, 0, 1, 0);
    #3 check("t5 write beats clear", 64'(dependency_mask), 64'h0000_0000_0080_0000);
    tick();
    in_pkt = mk(0, 3, 10, 1, 1, 0, 2);
    #3 check("t5 rs1=0 mask", 64'(dependency_mask), 64'd0);
    check("t5 rd0 disp_valid", 64'(disp_valid), 64'b0001);
    tick();
    in_pkt = mk(0, 3, 3, 1, 1, 0, 3);
    #3 check("t5 two sources", 64'(dependency_mask), 64'h0000_0020_0080_0000);
    tick();
    in_valid = 1'b0;
    #3 check("t5 rs1==rs2", 64'(dependency_mask), 64'h0000_0000_0080_0000);
    check("t5 fu3 disp_valid", 64'(disp_valid), 64'b1000);
    tick();

    // flush a stalled instruction
    in_valid = 1'b1; in_pkt = mk(0, 7, 10, 1, 1, 0, 3); rs_full = 4'b1000;
    tick();
    in_valid = 1'b0;
    #3 check("t6 held mask", 64'(dependency_mask), 64'h0000_0020_0000_0200);
    rs_full = '0; flush = 1'b1;
    #1 check("t6 flush disp_valid", 64'(disp_valid), 64'd0);
    check("t6 flush in_ready", 64'(in_ready), 64'd0);
    tick();
    flush = 1'b0; in_valid = 1'b1; in_pkt = mk(0, 7, 3, 1, 1, 0, 0);
    #3 check("t6 post flush disp_valid", 64'(disp_valid), 64'd0);
    check("t6 post flush in_ready", 64'(in_ready), 64'd1);
    tick();
    in_pkt = mk(1, 0, 0, 0, 0, 1, 3);
    #3 check("t6 table flushed", 64'(dependency_mask), 64'd0);
    check("t6 L disp_valid", 64'(disp_valid), 64'b0001);
    tick();
    in_valid = 1'b0; rs_full = 4'b1000;
    #3 check("t6 M stalled", 64'(disp_valid), 64'd0);
    rst = 1'b0;
    tick();
    #3 check("t6 rst in_ready", 64'(in_ready), 64'd0);
    check("t6 rst disp_valid", 64'(disp_valid), 64'd0);
    check("t6 rst mask", 64'(dependency_mask), 64'd0);
    check("t6 rst disp_pkt", 64'(disp_pkt), 64'd0);
    tick();
    rst = 1'b1; rs_full = '0;
    #3 check("t6 M discarded", 64'(disp_valid), 64'd0);
    check("t6 ready after rst", 64'(in_ready), 64'd1);
    tick();
    tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
